voice_mixer: RTL and testbench

//  Parametrised stereo successor to the mono voice-sum mixer. Consumes the per-voice

---
 rtl/mixer_pkg.sv | 24 ++
 rtl/voice_gain_ram.sv | 24 ++
 rtl/voice_mixer.sv | 169 ++++++++++++++++
 tb/tb_voice_mixer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mixer_pkg.sv
// Shared types and helpers for the stereo voice mixer: FSM state encoding,
// default unity gain and the signed saturation function.
package mixer_pkg;

  typedef enum logic {
    INIT,
    RUN
  } mix_state_t;

  localparam int DEF_GAIN_W = 9;
  localparam int UNITY_GAIN = 1 << (DEF_GAIN_W - 1);

  // Clamp a signed value to the range of a w-bit signed number.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/voice_gain_ram.sv
// Per-voice {left,right} gain table: one write port, one registered read port.
// A read and write of the same address in one cycle returns the old contents.
module voice_gain_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 18,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; the INIT state fills it.
  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/voice_mixer.sv
// Stereo voice mixer: per-voice L/R gain, frame accumulation and saturated output.
// Three-stage pipeline (table read, gain multiply, accumulate/saturate).
module voice_mixer
  import mixer_pkg::*;
#(
  parameter int N_VOICES = 256,
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = DEF_GAIN_W,
  parameter int OUT_W    = 24,
  localparam int VI_W    = $clog2(N_VOICES),
  localparam int ACC_W   = SAMPLE_W + 1 + VI_W
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_valid,
  input  logic [VI_W-1:0]            i_voice_index,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic                       i_last,
  input  logic                       i_cfg_we,
  input  logic [VI_W-1:0]            i_cfg_voice,
  input  logic [GAIN_W-1:0]          i_cfg_gain_l,
  input  logic [GAIN_W-1:0]          i_cfg_gain_r,
  input  logic                       i_clr_flags,
  output logic                       o_busy,
  output logic                       o_valid,
  output logic signed [OUT_W-1:0]    o_left,
  output logic signed [OUT_W-1:0]    o_right,
  output logic                       o_clip,
  output logic                       o_seq_err
);

  localparam logic [GAIN_W-1:0] UNITY = {1'b1, {(GAIN_W - 1){1'b0}}};
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
  localparam int P_W    = SAMPLE_W + 2;

  mix_state_t       state;
  logic [VI_W-1:0]  init_idx;
  logic [VI_W-1:0]  exp_idx;
  logic             accept;
  logic             seq_evt;

  logic               ram_we;
  logic [VI_W-1:0]    ram_waddr;
  logic [2*GAIN_W-1:0] ram_wdata;
  logic [2*GAIN_W-1:0] gain_rd;

  logic                       s1_valid, s1_last;
  logic signed [SAMPLE_W-1:0] s1_sample;
  logic                       s2_valid, s2_last;
  logic signed [P_W-1:0]      s2_pl, s2_pr;
  logic signed [ACC_W-1:0]    acc_l, acc_r;

  logic signed [PROD_W-1:0] prod_l, prod_r;
  logic signed [63:0]       sum_l, sum_r, acc_nl, acc_nr, out_nl, out_nr;
  logic                     clip_evt;

  assign accept  = i_valid && (state == RUN);
  assign seq_evt = accept && (i_voice_index != exp_idx);

  // INIT owns the write port; afterwards it belongs to the SPI configuration path.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = i_cfg_voice;
    ram_wdata = {i_cfg_gain_l, i_cfg_gain_r};
    if (state == INIT) begin
      ram_we    = 1'b1;
      ram_waddr = init_idx;
      ram_wdata = {UNITY, UNITY};
    end else if (i_cfg_we) begin
      ram_we = 1'b1;
    end
  end

  voice_gain_ram #(
    .DEPTH (N_VOICES),
    .WIDTH (2 * GAIN_W)
  ) u_gain_ram (
    .i_clk (i_clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (i_voice_index),
    .rdata (gain_rd)
  );

  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= INIT;
      init_idx  <= '0;
      o_busy    <= 1'b1;
      exp_idx   <= '0;
      o_seq_err <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == VI_W'(N_VOICES - 1)) begin
            state  <= RUN;
            o_busy <= 1'b0;
          end
        end
        RUN: begin
          if (accept) exp_idx <= i_last ? '0 : exp_idx + 1'b1;
        end
        default: state <= INIT;
      endcase
      o_seq_err <= (o_seq_err && !i_clr_flags) || seq_evt;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    prod_l   = s1_sample * $signed({1'b0, gain_rd[2*GAIN_W-1:GAIN_W]});
    prod_r   = s1_sample * $signed({1'b0, gain_rd[GAIN_W-1:0]});
    sum_l    = 64'(acc_l) + 64'(s2_pl);
    sum_r    = 64'(acc_r) + 64'(s2_pr);
    acc_nl   = sat(sum_l, ACC_W);
    acc_nr   = sat(sum_r, ACC_W);
    out_nl   = sat(acc_nl, OUT_W);
    out_nr   = sat(acc_nr, OUT_W);
    clip_evt = s2_valid && ((acc_nl != sum_l) || (acc_nr != sum_r) ||
               (s2_last && ((out_nl != acc_nl) || (out_nr != acc_nr))));
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_sample <= '0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_pl     <= '0;
      s2_pr     <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      o_valid   <= 1'b0;
      o_left    <= '0;
      o_right   <= '0;
      o_clip    <= 1'b0;
    end else begin
      s1_valid  <= accept;
      s1_last   <= accept && i_last;
      s1_sample <= i_sample;

      // Dropping the low GAIN_W-1 product bits is the arithmetic Q1 shift.
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_pl    <= prod_l[PROD_W-1:GAIN_W-1];
      s2_pr    <= prod_r[PROD_W-1:GAIN_W-1];

      o_valid <= 1'b0;
      if (s2_valid) begin
        if (s2_last) begin
          acc_l   <= '0;
          acc_r   <= '0;
          o_left  <= out_nl[OUT_W-1:0];
          o_right <= out_nr[OUT_W-1:0];
          o_valid <= 1'b1;
        end else begin
          acc_l <= acc_nl[ACC_W-1:0];
          acc_r <= acc_nr[ACC_W-1:0];
        end
      end
      o_clip <= (o_clip && !i_clr_flags) || clip_evt;
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer with 4 voices and 16-bit output.
// Expected values are hand-computed from the Q1.8 gain arithmetic.
module tb_voice_mixer;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_valid;
  logic [1:0]        i_voice_index;
  logic signed [15:0] i_sample;
  logic              i_last;
  logic              i_cfg_we;
  logic [1:0]        i_cfg_voice;
  logic [8:0]        i_cfg_gain_l;
  logic [8:0]        i_cfg_gain_r;
  logic              i_clr_flags;
  logic              o_busy;
  logic              o_valid;
  logic signed [15:0] o_left;
  logic signed [15:0] o_right;
  logic              o_clip;
  logic              o_seq_err;

  int n_checks = 0;
  int n_pass   = 0;
  int valid_count = 0;
  logic signed [15:0] cap_l[$];
  logic signed [15:0] cap_r[$];

  voice_mixer #(
    .N_VOICES (4),
    .SAMPLE_W (16),
    .GAIN_W   (9),
    .OUT_W    (16)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .i_voice_index (i_voice_index),
    .i_sample      (i_sample),
    .i_last        (i_last),
    .i_cfg_we      (i_cfg_we),
    .i_cfg_voice   (i_cfg_voice),
    .i_cfg_gain_l  (i_cfg_gain_l),
    .i_cfg_gain_r  (i_cfg_gain_r),
    .i_clr_flags   (i_clr_flags),
    .o_busy        (o_busy),
    .o_valid       (o_valid),
    .o_left        (o_left),
    .o_right       (o_right),
    .o_clip        (o_clip),
    .o_seq_err     (o_seq_err)
  );

  always #5 i_clk = ~i_clk;

  // Frame capture, sampled just after the active edge.
  always @(posedge i_clk) begin
    #1;
    if (o_valid === 1'b1) begin
      valid_count++;
      cap_l.push_back(o_left);
      cap_r.push_back(o_right);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge i_clk);
  endtask

  task automatic send(input int idx, input int s, input logic l);
    i_valid       = 1'b1;
    i_voice_index = idx[1:0];
    i_sample      = s[15:0];
    i_last        = l;
    @(negedge i_clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic cfg(input int v, input int gl, input int gr);
    i_cfg_we     = 1'b1;
    i_cfg_voice  = v[1:0];
    i_cfg_gain_l = gl[8:0];
    i_cfg_gain_r = gr[8:0];
    @(negedge i_clk);
    i_cfg_we = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (o_valid !== 1'b1 && k < 12) begin
      @(negedge i_clk);
      k++;
    end
    check(tag, 32'(o_valid), 32'd1);
  endtask

  task automatic busy_cycles(input string tag);
    int n = 0;
    while (o_busy === 1'b1 && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    check(tag, n, 4);
  endtask

  initial begin
    int vc;
    i_reset = 1'b1; i_valid = 1'b0; i_voice_index = '0; i_sample = '0; i_last = 1'b0;
    i_cfg_we = 1'b0; i_cfg_voice = '0; i_cfg_gain_l = '0; i_cfg_gain_r = '0;
    i_clr_flags = 1'b0;
    idle(2);

    // 1: reset state and INIT length
    check("rst_busy", 32'(o_busy), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_left", 32'(o_left), 32'd0);
    check("rst_right", 32'(o_right), 32'd0);
    check("rst_clip", 32'(o_clip), 32'd0);
    check("rst_seq", 32'(o_seq_err), 32'd0);
    i_reset = 1'b0;
    busy_cycles("init_busy_cycles");
    check("init_no_valid", valid_count, 0);

    // 2: unity gains, latency of exactly 3 cycles
    send(0, 100, 1'b0);
    send(1, 200, 1'b0);
    send(2, -50, 1'b0);
    send(3, 1000, 1'b1);
    check("lat_c1", 32'(o_valid), 32'd0);
    idle(1);
    check("lat_c2", 32'(o_valid), 32'd0);
    idle(1);
    check("lat_c3", 32'(o_valid), 32'd1);
    check("unity_left", 32'(o_left), 32'd1250);
    check("unity_right", 32'(o_right), 32'd1250);
    idle(1);
    check("valid_pulse", 32'(o_valid), 32'd0);
    check("left_held", 32'(o_left), 32'd1250);

    // 3: voice1 L=0, R=511 (largest Q1.8 gain); 200*511>>8 = 399; gaps in the frame
    cfg(1, 0, 511);
    send(0, 100, 1'b0);
    idle(1);
    send(1, 200, 1'b0);
    send(2, -50, 1'b0);
    idle(2);
    send(3, 1000, 1'b1);
    wait_valid("gain_valid");
    check("gain_left", 32'(o_left), 32'd1050);
    check("gain_right", 32'(o_right), 32'd1449);

    // 4: 4 x 32767 at gain 511 -> 4*65406 = 261624, clamps to 32767
    for (int v = 0; v < 4; v++) cfg(v, 511, 511);
    for (int v = 0; v < 4; v++) send(v, 32767, v == 3);
    wait_valid("sat_valid");
    check("sat_left", 32'(o_left), 32'd32767);
    check("sat_right", 32'(o_right), 32'd32767);
    check("clip_set", 32'(o_clip), 32'd1);
    idle(3);
    check("clip_sticky", 32'(o_clip), 32'd1);
    i_clr_flags = 1'b1;
    idle(1);
    i_clr_flags = 1'b0;
    check("clip_cleared", 32'(o_clip), 32'd0);

    // 5: out-of-order indices at gain 511: 511+1022-511+2044 = 3066
    send(0, 256, 1'b0);
    send(2, 512, 1'b0);
    send(1, -256, 1'b0);
    send(3, 1024, 1'b1);
    wait_valid("seq_valid");
    check("seq_err_set", 32'(o_seq_err), 32'd1);
    check("seq_left", 32'(o_left), 32'd3066);
    check("seq_right", 32'(o_right), 32'd3066);
    check("seq_no_clip", 32'(o_clip), 32'd0);
    i_clr_flags = 1'b1;
    idle(1);
    i_clr_flags = 1'b0;
    check("seq_err_cleared", 32'(o_seq_err), 32'd0);

    // 5b: reset while a closing frame is still in the pipeline
    vc = valid_count;
    for (int v = 0; v < 4; v++) send(v, 1000, v == 3);
    i_reset = 1'b1;
    idle(1);
    check("midrst_busy", 32'(o_busy), 32'd1);
    i_reset = 1'b0;
    busy_cycles("reinit_busy_cycles");
    idle(4);
    check("midrst_no_valid", valid_count, vc);
    for (int v = 0; v < 4; v++) send(v, 1, v == 3);
    wait_valid("post_rst_valid");
    check("post_rst_left", 32'(o_left), 32'd4);
    check("post_rst_right", 32'(o_right), 32'd4);

    // 6: three frames back-to-back; voice2 rewritten during its read in frame B
    idle(1);
    cap_l.delete();
    cap_r.delete();
    send(0, 10, 1'b0); send(1, 20, 1'b0); send(2, 30, 1'b0); send(3, 40, 1'b1);
    send(0, 1, 1'b0);  send(1, 2, 1'b0);
    i_cfg_we = 1'b1; i_cfg_voice = 2'd2; i_cfg_gain_l = 9'd128; i_cfg_gain_r = 9'd256;
    send(2, 3, 1'b0);
    i_cfg_we = 1'b0;
    send(3, 4, 1'b1);
    send(0, 100, 1'b0); send(1, 200, 1'b0); send(2, 300, 1'b0); send(3, 400, 1'b1);
    idle(6);
    check("b2b_frames", cap_l.size(), 3);
    if (cap_l.size() == 3 && cap_r.size() == 3) begin
      check("b2b_a_left", 32'(cap_l[0]), 32'd100);
      check("b2b_a_right", 32'(cap_r[0]), 32'd100);
      check("b2b_b_left_old_gain", 32'(cap_l[1]), 32'd10);
      check("b2b_b_right", 32'(cap_r[1]), 32'd10);
      check("b2b_c_left_new_gain", 32'(cap_l[2]), 32'd850);
      check("b2b_c_right", 32'(cap_r[2]), 32'd1000);
    end
    check("b2b_seq_ok", 32'(o_seq_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
